ibex_axi_arbiter: RTL and testbench



---
 rtl/ibex_axi_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ibex_axi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_axi_arbiter.sv
// ibex_axi_arbiter: 2:1 AXI4 arbiter that merges the Ibex instruction and data ports onto one master port.
// Define IBEX_AXI_ARB_RR_EN for round-robin arbitration; without it, s1 (data) has fixed priority over s0.
package ibex_axi_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;
endpackage

module ibex_axi_arbiter #(
  parameter type axi_req_t = ibex_axi_arbiter_pkg::axi_req_t,
  parameter type axi_rsp_t = ibex_axi_arbiter_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t s0_req_i,
  output axi_rsp_t s0_rsp_o,
  input  axi_req_t s1_req_i,
  output axi_rsp_t s1_rsp_o,
  output axi_req_t m_req_o,
  input  axi_rsp_t m_rsp_i,
  output logic     rd_grant_o,
  output logic     wr_grant_o,
  output logic     rd_busy_o,
  output logic     wr_busy_o
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wr_state_e;
  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic rd_grant_q, rd_grant_d, wr_grant_q, wr_grant_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_any, wr_any, rd_pick, wr_pick;
  logic rd_ar_ready, rd_r_valid, wr_aw_ready, wr_w_ready, wr_b_valid;
  axi_req_t rd_req, wr_req;

  assign rd_any = s0_req_i.ar_valid | s1_req_i.ar_valid;
  assign wr_any = s0_req_i.aw_valid | s1_req_i.aw_valid;

`ifdef IBEX_AXI_ARB_RR_EN
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  assign rd_pick = (s0_req_i.ar_valid & s1_req_i.ar_valid) ? ~rd_ptr_q : s1_req_i.ar_valid;
  assign wr_pick = (s0_req_i.aw_valid & s1_req_i.aw_valid) ? ~wr_ptr_q : s1_req_i.aw_valid;
  assign rd_ptr_d = (rd_state_q == R_IDLE && rd_any) ? rd_pick : rd_ptr_q;
  assign wr_ptr_d = (wr_state_q == W_IDLE && wr_any) ? wr_pick : wr_ptr_q;
  // last-granted pointers; reset to s0 so the first tie goes to s1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`else
  assign rd_pick = s1_req_i.ar_valid;
  assign wr_pick = s1_req_i.aw_valid;
`endif

  // state, grant and write-completion registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_grant_q <= 1'b1;
      wr_grant_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // next state and channel muxing; valids only leave the block from the owning FSM state
  always_comb begin
    rd_state_d  = rd_state_q;
    wr_state_d  = wr_state_q;
    rd_grant_d  = rd_grant_q;
    wr_grant_d  = wr_grant_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rd_ar_ready = 1'b0;
    rd_r_valid  = 1'b0;
    wr_aw_ready = 1'b0;
    wr_w_ready  = 1'b0;
    wr_b_valid  = 1'b0;
    rd_req      = rd_grant_q ? s1_req_i : s0_req_i;
    wr_req      = wr_grant_q ? s1_req_i : s0_req_i;
    m_req_o     = '0;
    m_req_o.ar  = rd_req.ar;
    m_req_o.aw  = wr_req.aw;
    m_req_o.w   = wr_req.w;
    case (rd_state_q)
      R_IDLE: if (rd_any) begin
        rd_grant_d = rd_pick;
        rd_state_d = R_ADDR;
      end
      R_ADDR: begin
        m_req_o.ar_valid = rd_req.ar_valid;
        rd_ar_ready      = m_rsp_i.ar_ready;
        if (rd_req.ar_valid && m_rsp_i.ar_ready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_req_o.r_ready = rd_req.r_ready;
        rd_r_valid      = m_rsp_i.r_valid;
        if (m_rsp_i.r_valid && rd_req.r_ready && m_rsp_i.r.last) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    case (wr_state_q)
      W_IDLE: if (wr_any) begin
        wr_grant_d = wr_pick;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        wr_state_d = W_BUSY;
      end
      W_BUSY: begin
        m_req_o.aw_valid = wr_req.aw_valid & ~aw_done_q;
        m_req_o.w_valid  = wr_req.w_valid & ~w_done_q;
        wr_aw_ready      = m_rsp_i.aw_ready & ~aw_done_q;
        wr_w_ready       = m_rsp_i.w_ready & ~w_done_q;
        if (m_req_o.aw_valid && m_rsp_i.aw_ready) aw_done_d = 1'b1;
        if (m_req_o.w_valid && m_rsp_i.w_ready && wr_req.w.last) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_req_o.b_ready = wr_req.b_ready;
        wr_b_valid      = m_rsp_i.b_valid;
        if (m_rsp_i.b_valid && wr_req.b_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    s0_rsp_o          = '0;
    s1_rsp_o          = '0;
    s0_rsp_o.r        = m_rsp_i.r;
    s1_rsp_o.r        = m_rsp_i.r;
    s0_rsp_o.b        = m_rsp_i.b;
    s1_rsp_o.b        = m_rsp_i.b;
    s0_rsp_o.ar_ready = ~rd_grant_q & rd_ar_ready;
    s1_rsp_o.ar_ready = rd_grant_q & rd_ar_ready;
    s0_rsp_o.r_valid  = ~rd_grant_q & rd_r_valid;
    s1_rsp_o.r_valid  = rd_grant_q & rd_r_valid;
    s0_rsp_o.aw_ready = ~wr_grant_q & wr_aw_ready;
    s1_rsp_o.aw_ready = wr_grant_q & wr_aw_ready;
    s0_rsp_o.w_ready  = ~wr_grant_q & wr_w_ready;
    s1_rsp_o.w_ready  = wr_grant_q & wr_w_ready;
    s0_rsp_o.b_valid  = ~wr_grant_q & wr_b_valid;
    s1_rsp_o.b_valid  = wr_grant_q & wr_b_valid;
  end

  assign rd_grant_o = rd_grant_q;
  assign wr_grant_o = wr_grant_q;
  assign rd_busy_o  = rd_state_q != R_IDLE;
  assign wr_busy_o  = wr_state_q != W_IDLE;
endmodule

// File: tb/tb_ibex_axi_arbiter.sv
// tb_ibex_axi_arbiter: directed self-checking bench for ibex_axi_arbiter.
module tb_ibex_axi_arbiter;
  import ibex_axi_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_req_t s0_req, s1_req, m_req;
  axi_rsp_t s0_rsp, s1_rsp, m_rsp;
  logic rd_grant, wr_grant, rd_busy, wr_busy;
  int checks = 0;
  int errors = 0;

  ibex_axi_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s0_req_i(s0_req), .s0_rsp_o(s0_rsp),
    .s1_req_i(s1_req), .s1_rsp_o(s1_rsp),
    .m_req_o(m_req), .m_rsp_i(m_rsp),
    .rd_grant_o(rd_grant), .wr_grant_o(wr_grant),
    .rd_busy_o(rd_busy), .wr_busy_o(wr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_txn(input string name, output logic g, output logic [31:0] a);
    int n = 0;
    while (!m_req.ar_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL %s ar_valid timeout: got 0 want 1", name);
    end
    g = rd_grant;
    a = m_req.ar.addr;
    m_rsp.ar_ready = 1'b1;
    tick();
    m_rsp.ar_ready = 1'b0;
    m_rsp.r_valid = 1'b1;
    m_rsp.r.last = 1'b1;
    m_rsp.r.data = a;
    #1;
    checks++;
    if ({s1_rsp.r_valid, s0_rsp.r_valid} !== (g ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s r routing: got %b want %b", name, {s1_rsp.r_valid, s0_rsp.r_valid}, g ? 2'b10 : 2'b01);
    end
    tick();
    m_rsp.r_valid = 1'b0;
    m_rsp.r.last = 1'b0;
  endtask

  task automatic test_reset();
    s0_req = '0;
    s1_req = '0;
    m_rsp = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.b_ready, m_req.r_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset m valids: got %b want 00000", {m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.b_ready, m_req.r_ready});
    end
    checks++;
    if ({rd_grant, wr_grant, rd_busy, wr_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL reset grant/busy: got %b want 1100", {rd_grant, wr_grant, rd_busy, wr_busy});
    end
    checks++;
    if ({s0_rsp.ar_ready, s0_rsp.r_valid, s0_rsp.aw_ready, s0_rsp.w_ready, s0_rsp.b_valid,
         s1_rsp.ar_ready, s1_rsp.r_valid, s1_rsp.aw_ready, s1_rsp.w_ready, s1_rsp.b_valid} !== 10'b0) begin
      errors++;
      $display("FAIL reset slave rsp: nonzero ready/valid");
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_single();
    s0_req.ar.addr = 32'h100;
    s0_req.ar.len = 8'd3;
    s0_req.ar_valid = 1'b1;
    s0_req.r_ready = 1'b1;
    #1;
    checks++;
    if (m_req.ar_valid !== 1'b0) begin
      errors++;
      $display("FAIL read bubble ar_valid: got %b want 0", m_req.ar_valid);
    end
    tick();
    checks++;
    if ({m_req.ar_valid, m_req.ar.addr, rd_grant, rd_busy} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL read addr phase: got v=%b a=%h g=%b b=%b want v=1 a=100 g=0 b=1", m_req.ar_valid, m_req.ar.addr, rd_grant, rd_busy);
    end
    m_rsp.ar_ready = 1'b1;
    #1;
    checks++;
    if ({s0_rsp.ar_ready, s1_rsp.ar_ready} !== 2'b10) begin
      errors++;
      $display("FAIL read ar_ready route: got %b want 10", {s0_rsp.ar_ready, s1_rsp.ar_ready});
    end
    tick();
    s0_req.ar_valid = 1'b0;
    m_rsp.ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rsp.r_valid = 1'b1;
      m_rsp.r.data = 32'hA0 + i;
      m_rsp.r.last = (i == 3);
      #1;
      checks++;
      if ({s0_rsp.r_valid, s0_rsp.r.data, s1_rsp.r_valid, m_req.r_ready} !== {1'b1, 32'hA0 + i, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL read beat %0d: got v0=%b d=%h v1=%b rr=%b", i, s0_rsp.r_valid, s0_rsp.r.data, s1_rsp.r_valid, m_req.r_ready);
      end
      tick();
    end
    m_rsp.r_valid = 1'b0;
    m_rsp.r.last = 1'b0;
    #1;
    checks++;
    if (rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL read idle after last: rd_busy got %b want 0", rd_busy);
    end
    s0_req.r_ready = 1'b0;
    tick();
  endtask

  task automatic test_read_arbitration();
    logic g;
    logic [31:0] a;
    logic exp_g;
    s0_req.ar.addr = 32'h200;
    s1_req.ar.addr = 32'h300;
    s0_req.r_ready = 1'b1;
    s1_req.r_ready = 1'b1;
    s0_req.ar_valid = 1'b1;
    s1_req.ar_valid = 1'b1;
    rd_txn("tie first", g, a);
    checks++;
    if ({g, a} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL tie first: got g=%b a=%h want g=1 a=300", g, a);
    end
    s1_req.ar_valid = 1'b0;
    rd_txn("tie second", g, a);
    checks++;
    if ({g, a} !== {1'b0, 32'h200}) begin
      errors++;
      $display("FAIL tie second: got g=%b a=%h want g=0 a=200", g, a);
    end
    s1_req.ar_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef IBEX_AXI_ARB_RR_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      rd_txn("contend", g, a);
      checks++;
      if ({g, a} !== {exp_g, exp_g ? 32'h300 : 32'h200}) begin
        errors++;
        $display("FAIL contend %0d: got g=%b a=%h want g=%b", i, g, a, exp_g);
      end
    end
    s0_req.ar_valid = 1'b0;
    s1_req.ar_valid = 1'b0;
    s0_req.r_ready = 1'b0;
    s1_req.r_ready = 1'b0;
    tick();
  endtask

  task automatic test_write();
    m_rsp.w_ready = 1'b1;
    s1_req.w.data = 32'hDEADBEEF;
    s1_req.w.strb = 4'hF;
    s1_req.w.last = 1'b1;
    s1_req.w_valid = 1'b1;
    s1_req.b_ready = 1'b1;
    #1;
    checks++;
    if ({m_req.w_valid, wr_busy} !== 2'b00) begin
      errors++;
      $display("FAIL write w alone: got w_valid=%b busy=%b want 0 0", m_req.w_valid, wr_busy);
    end
    tick();
    tick();
    s1_req.aw.addr = 32'h400;
    s1_req.aw_valid = 1'b1;
    tick();
    checks++;
    if ({m_req.w_valid, m_req.w.data, m_req.w.strb, m_req.aw_valid, m_req.aw.addr, s1_rsp.w_ready, s0_rsp.w_ready, wr_grant}
        !== {1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL write busy: got wv=%b d=%h awv=%b a=%h wr1=%b wr0=%b g=%b", m_req.w_valid, m_req.w.data, m_req.aw_valid, m_req.aw.addr, s1_rsp.w_ready, s0_rsp.w_ready, wr_grant);
    end
    tick();
    s1_req.w_valid = 1'b0;
    #1;
    checks++;
    if ({m_req.w_valid, m_req.aw_valid, wr_busy} !== 3'b011) begin
      errors++;
      $display("FAIL write w masked: got %b want 011", {m_req.w_valid, m_req.aw_valid, wr_busy});
    end
    tick();
    m_rsp.aw_ready = 1'b1;
    #1;
    checks++;
    if ({s1_rsp.aw_ready, s0_rsp.aw_ready} !== 2'b10) begin
      errors++;
      $display("FAIL write aw_ready route: got %b want 10", {s1_rsp.aw_ready, s0_rsp.aw_ready});
    end
    tick();
    s1_req.aw_valid = 1'b0;
    m_rsp.aw_ready = 1'b0;
    m_rsp.b_valid = 1'b1;
    m_rsp.b.resp = 2'b00;
    #1;
    checks++;
    if ({m_req.aw_valid, m_req.b_ready, s1_rsp.b_valid, s0_rsp.b_valid, s1_rsp.b.resp, wr_busy} !== 7'b0110001) begin
      errors++;
      $display("FAIL write resp: got %b want 0110001", {m_req.aw_valid, m_req.b_ready, s1_rsp.b_valid, s0_rsp.b_valid, s1_rsp.b.resp, wr_busy});
    end
    tick();
    m_rsp.b_valid = 1'b0;
    #1;
    checks++;
    if (wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL write done busy: got %b want 0", wr_busy);
    end
    s1_req.b_ready = 1'b0;
    m_rsp.w_ready = 1'b0;
    tick();
  endtask

  task automatic test_concurrent();
    s0_req.ar.addr = 32'h500;
    s0_req.ar_valid = 1'b1;
    s0_req.r_ready = 1'b1;
    s1_req.aw.addr = 32'h600;
    s1_req.aw_valid = 1'b1;
    s1_req.w.data = 32'h12345678;
    s1_req.w.last = 1'b1;
    s1_req.w_valid = 1'b1;
    s1_req.b_ready = 1'b1;
    tick();
    checks++;
    if ({rd_grant, wr_grant, rd_busy, wr_busy, m_req.ar.addr, m_req.aw.addr} !== {4'b0111, 32'h500, 32'h600}) begin
      errors++;
      $display("FAIL concurrent grant: got rg=%b wg=%b rb=%b wb=%b ar=%h aw=%h", rd_grant, wr_grant, rd_busy, wr_busy, m_req.ar.addr, m_req.aw.addr);
    end
    m_rsp.ar_ready = 1'b1;
    m_rsp.aw_ready = 1'b1;
    m_rsp.w_ready = 1'b1;
    #1;
    checks++;
    if ({s0_rsp.ar_ready, s1_rsp.ar_ready, s1_rsp.aw_ready, s0_rsp.aw_ready, s1_rsp.w_ready, s0_rsp.w_ready} !== 6'b101010) begin
      errors++;
      $display("FAIL concurrent readies: got %b want 101010", {s0_rsp.ar_ready, s1_rsp.ar_ready, s1_rsp.aw_ready, s0_rsp.aw_ready, s1_rsp.w_ready, s0_rsp.w_ready});
    end
    tick();
    s0_req.ar_valid = 1'b0;
    s1_req.aw_valid = 1'b0;
    s1_req.w_valid = 1'b0;
    m_rsp.ar_ready = 1'b0;
    m_rsp.aw_ready = 1'b0;
    m_rsp.w_ready = 1'b0;
    m_rsp.r_valid = 1'b1;
    m_rsp.r.last = 1'b1;
    m_rsp.b_valid = 1'b1;
    #1;
    checks++;
    if ({s0_rsp.r_valid, s1_rsp.r_valid, s1_rsp.b_valid, s0_rsp.b_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL concurrent resp route: got %b want 1010", {s0_rsp.r_valid, s1_rsp.r_valid, s1_rsp.b_valid, s0_rsp.b_valid});
    end
    tick();
    m_rsp.r_valid = 1'b0;
    m_rsp.r.last = 1'b0;
    m_rsp.b_valid = 1'b0;
    #1;
    checks++;
    if ({rd_busy, wr_busy} !== 2'b00) begin
      errors++;
      $display("FAIL concurrent done: got %b want 00", {rd_busy, wr_busy});
    end
    s0_req.r_ready = 1'b0;
    s1_req.b_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic g;
    logic [31:0] a;
    s0_req.ar.addr = 32'h700;
    s0_req.ar.len = 8'd3;
    s0_req.ar_valid = 1'b1;
    s0_req.r_ready = 1'b1;
    tick();
    m_rsp.ar_ready = 1'b1;
    tick();
    s0_req.ar_valid = 1'b0;
    m_rsp.ar_ready = 1'b0;
    m_rsp.r_valid = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({m_req.r_ready, s0_rsp.r_valid, rd_busy} !== 3'b111) begin
      errors++;
      $display("FAIL mid-burst state: got %b want 111", {m_req.r_ready, s0_rsp.r_valid, rd_busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_req.r_ready, s0_rsp.r_valid, m_req.ar_valid, rd_busy, rd_grant} !== 5'b00001) begin
      errors++;
      $display("FAIL async reset: got %b want 00001", {m_req.r_ready, s0_rsp.r_valid, m_req.ar_valid, rd_busy, rd_grant});
    end
    m_rsp.r_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    s0_req.ar.addr = 32'h800;
    s0_req.ar_valid = 1'b1;
    rd_txn("after reset", g, a);
    checks++;
    if ({g, a} !== {1'b0, 32'h800}) begin
      errors++;
      $display("FAIL after reset grant: got g=%b a=%h want g=0 a=800", g, a);
    end
    s0_req.ar_valid = 1'b0;
    s0_req.r_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_read_arbitration();
    test_write();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
